// File: rtl/vote_pkg.sv
// Shared encodings, FSM states and ballot validation for the voting datapath.
package vote_pkg;

  localparam logic [2:0] CAND_A    = 3'b100;
  localparam logic [2:0] CAND_B    = 3'b010;
  localparam logic [2:0] CAND_C    = 3'b001;
  localparam logic [2:0] NO_WINNER = 3'b000;

  typedef enum logic [1:0] {
    COLLECT,
    TALLY,
    RESULT
  } state_e;

  // A ballot counts only when exactly one candidate bit is set.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == CAND_A) || (v == CAND_B) || (v == CAND_C);
  endfunction

endpackage

// File: rtl/vote_argmax.sv
// Combinational plurality decision over three candidate tallies.
module vote_argmax
  import vote_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt_a_i,
  input  logic [CNT_W-1:0] cnt_b_i,
  input  logic [CNT_W-1:0] cnt_c_i,
  output logic [2:0]       winner_o,
  output logic             tie_o
);

  // Only a strict maximum wins; any shared maximum is reported as a tie.
  always_comb begin
    winner_o = NO_WINNER;
    tie_o    = 1'b0;
    if ((cnt_a_i > cnt_b_i) && (cnt_a_i > cnt_c_i)) begin
      winner_o = CAND_A;
    end else if ((cnt_b_i > cnt_a_i) && (cnt_b_i > cnt_c_i)) begin
      winner_o = CAND_B;
    end else if ((cnt_c_i > cnt_a_i) && (cnt_c_i > cnt_b_i)) begin
      winner_o = CAND_C;
    end else begin
      tie_o = 1'b1;
    end
  end

endmodule

// File: rtl/vote_ballot_collector.sv
// Serial ballot collector: counts one-hot ballots, flags malformed ones and
// presents the plurality winner on a valid/ready result port.
module vote_ballot_collector
  import vote_pkg::*;
#(
  parameter int NUM_VOTERS = 5,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       ballot,
  input  logic             ballot_valid,
  output logic             ballot_ready,
  output logic             ballot_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       winner,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  // Counters cannot wrap only if the tally width covers a unanimous vote.
  if ((2 ** CNT_W) <= NUM_VOTERS || NUM_VOTERS < 1 || NUM_VOTERS > 15) begin : g_param_check
    $error("vote_ballot_collector: need 1 <= NUM_VOTERS <= 15 and 2**CNT_W > NUM_VOTERS");
  end

  localparam logic [CNT_W-1:0] LAST_BALLOT = CNT_W'(NUM_VOTERS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic [CNT_W-1:0] cnt_c_q;
  logic [CNT_W-1:0] ballot_cnt_q;
  logic             ready_q;
  logic             err_q;
  logic             res_valid_q;
  logic [2:0]       winner_q;
  logic             tie_q;

  logic             accept;
  logic             ballot_ok;
  logic [2:0]       argmax_winner;
  logic             argmax_tie;

  assign accept    = ballot_valid & ready_q;
  assign ballot_ok = is_onehot3(ballot);

  vote_argmax #(
    .CNT_W (CNT_W)
  ) u_argmax (
    .cnt_a_i  (cnt_a_q),
    .cnt_b_i  (cnt_b_q),
    .cnt_c_i  (cnt_c_q),
    .winner_o (argmax_winner),
    .tie_o    (argmax_tie)
  );

  // Election control: collect ballots, latch the decision, hold it until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      cnt_c_q      <= '0;
      ballot_cnt_q <= '0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
      res_valid_q  <= 1'b0;
      winner_q     <= NO_WINNER;
      tie_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (ballot_ok) begin
              if (ballot == CAND_A) cnt_a_q <= cnt_a_q + 1'b1;
              if (ballot == CAND_B) cnt_b_q <= cnt_b_q + 1'b1;
              if (ballot == CAND_C) cnt_c_q <= cnt_c_q + 1'b1;
              ballot_cnt_q <= ballot_cnt_q + 1'b1;
              // Stop accepting as soon as the last voter is in.
              if (ballot_cnt_q == LAST_BALLOT) begin
                state_q <= TALLY;
                ready_q <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        TALLY: begin
          winner_q <= argmax_winner;
          tie_q    <= argmax_tie;
          state_q  <= RESULT;
        end
        RESULT: begin
          // The result port opens one cycle after the decision is latched,
          // so a consumer never sees res_valid before winner/tie settle.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
          end else if (res_ready) begin
            res_valid_q  <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            cnt_c_q      <= '0;
            ballot_cnt_q <= '0;
            ready_q      <= 1'b1;
            state_q      <= COLLECT;
          end
        end
        default: begin
          state_q <= COLLECT;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ballot_ready = ready_q;
  assign ballot_err   = err_q;
  assign res_valid    = res_valid_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign cnt_a        = cnt_a_q;
  assign cnt_b        = cnt_b_q;
  assign cnt_c        = cnt_c_q;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for the serial ballot collector.
module tb_vote_ballot_collector;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       ballot;
  logic             ballot_valid;
  logic             ballot_ready;
  logic             ballot_err;
  logic             res_valid;
  logic             res_ready;
  logic [2:0]       winner;
  logic             tie;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W-1:0] cnt_c;

  int total = 0;
  int bad   = 0;

  vote_ballot_collector #(
    .NUM_VOTERS (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ballot       (ballot),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .ballot_err   (ballot_err),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .winner       (winner),
    .tie          (tie),
    .cnt_a        (cnt_a),
    .cnt_b        (cnt_b),
    .cnt_c        (cnt_c)
  );

  always #5 clk = ~clk;

  // Presents one ballot from a negedge and returns #1 after the edge that takes it.
  task automatic drive_ballot(input logic [2:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    ballot       = b;
    ballot_valid = 1'b1;
    while (!ballot_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout ballot=%b ballot_ready=%b required=1", b, ballot_ready);
    end
    @(posedge clk);
    #1;
    ballot_valid = 1'b0;
    ballot       = 3'b000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++; if (ballot_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ballot_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++; if (ballot_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", ballot_err); end
    total++; if (winner !== 3'b000 || tie !== 1'b0) begin bad++; $display("FAIL rst_winner got=%b/%b exp=000/0", winner, tie); end
    total++; if ({cnt_a, cnt_b, cnt_c} !== '0) begin bad++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", cnt_a, cnt_b, cnt_c); end
  endtask

  task automatic test_plurality();
    logic [2:0] seq [5];
    seq = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b010};
    res_ready = 1'b1;
    foreach (seq[i]) drive_ballot(seq[i]);
    // Edge N just passed: decision still pending.
    total++; if (ballot_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_tally got=%b exp=0", ballot_ready); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0 at N+1", res_valid); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL t1_latency got=%b exp=1 at N+2", res_valid); end
    total++; if (winner !== 3'b100 || tie !== 1'b0) begin bad++; $display("FAIL t1_winner got=%b/%b exp=100/0", winner, tie); end
    total++; if (cnt_a !== 4'd3 || cnt_b !== 4'd1 || cnt_c !== 4'd1) begin bad++; $display("FAIL t1_counts got=%0d/%0d/%0d exp=3/1/1", cnt_a, cnt_b, cnt_c); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0 || ballot_ready !== 1'b1) begin bad++; $display("FAIL t1_release got valid=%b ready=%b exp 0/1", res_valid, ballot_ready); end
  endtask

  task automatic test_tie();
    logic [2:0] seq [5];
    int guard;
    seq = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b010};
    res_ready = 1'b1;
    foreach (seq[i]) drive_ballot(seq[i]);
    guard = 0;
    while (res_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL t2_result_timeout got=%b exp=1", res_valid); end
    total++; if (winner !== 3'b000 || tie !== 1'b1) begin bad++; $display("FAIL t2_tie got=%b/%b exp=000/1", winner, tie); end
    total++; if (cnt_a !== 4'd2 || cnt_b !== 4'd2 || cnt_c !== 4'd1) begin bad++; $display("FAIL t2_counts got=%0d/%0d/%0d exp=2/2/1", cnt_a, cnt_b, cnt_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_ballots();
    logic [2:0] seq  [7];
    logic       errx [7];
    int guard;
    seq  = '{3'b100, 3'b011, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001};
    errx = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    res_ready = 1'b1;
    foreach (seq[i]) begin
      drive_ballot(seq[i]);
      total++;
      if (ballot_err !== errx[i]) begin bad++; $display("FAIL t3_err[%0d] ballot=%b got=%b exp=%b", i, seq[i], ballot_err, errx[i]); end
    end
    @(posedge clk); #1;
    total++; if (ballot_err !== 1'b0) begin bad++; $display("FAIL t3_err_idle got=%b exp=0", ballot_err); end
    guard = 0;
    while (res_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    total++; if (winner !== 3'b001 || tie !== 1'b0) begin bad++; $display("FAIL t3_winner got=%b/%b exp=001/0", winner, tie); end
    total++; if (cnt_a !== 4'd1 || cnt_b !== 4'd0 || cnt_c !== 4'd4) begin bad++; $display("FAIL t3_counts got=%0d/%0d/%0d exp=1/0/4", cnt_a, cnt_b, cnt_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int guard;
    res_ready = 1'b0;
    repeat (5) drive_ballot(3'b010);
    guard = 0;
    while (res_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (res_valid !== 1'b1 || ballot_ready !== 1'b0 || winner !== 3'b010 || tie !== 1'b0 || cnt_b !== 4'd5 || cnt_a !== 4'd0 || cnt_c !== 4'd0) begin
        bad++;
        $display("FAIL t4_hold[%0d] got valid=%b ready=%b win=%b tie=%b cnt=%0d/%0d/%0d exp 1/0/010/0/0/5/0",
                 k, res_valid, ballot_ready, winner, tie, cnt_a, cnt_b, cnt_c);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0 || ballot_ready !== 1'b1) begin bad++; $display("FAIL t4_release got valid=%b ready=%b exp 0/1", res_valid, ballot_ready); end
    total++; if ({cnt_a, cnt_b, cnt_c} !== '0) begin bad++; $display("FAIL t4_cleared got=%0d/%0d/%0d exp=0/0/0", cnt_a, cnt_b, cnt_c); end
  endtask

  task automatic test_mid_reset();
    int guard;
    res_ready = 1'b1;
    repeat (3) drive_ballot(3'b100);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total++; if (cnt_a !== 4'd0 || ballot_ready !== 1'b1) begin bad++; $display("FAIL t5_reset got cnt_a=%0d ready=%b exp 0/1", cnt_a, ballot_ready); end
    repeat (5) drive_ballot(3'b001);
    guard = 0;
    while (res_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    total++; if (winner !== 3'b001 || cnt_a !== 4'd0 || cnt_c !== 4'd5) begin bad++; $display("FAIL t5_result got win=%b cnt_a=%0d cnt_c=%0d exp 001/0/5", winner, cnt_a, cnt_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    logic [2:0] seq [5];
    int guard;
    seq = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
    res_ready = 1'b0;
    foreach (seq[i]) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      drive_ballot(seq[i]);
    end
    // Keep offering a ballot while the collector is busy; it must not be taken.
    ballot       = 3'b100;
    ballot_valid = 1'b1;
    guard = 0;
    while (res_valid !== 1'b1 && guard < 10) begin @(posedge clk); #1; guard++; end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (res_valid !== 1'b1 || winner !== 3'b001) begin bad++; $display("FAIL t6_result got valid=%b win=%b exp 1/001", res_valid, winner); end
    total++; if (cnt_a !== 4'd1 || cnt_c !== 4'd4) begin bad++; $display("FAIL t6_no_consume got cnt_a=%0d cnt_c=%0d exp 1/4", cnt_a, cnt_c); end
    @(negedge clk);
    ballot_valid = 1'b0;
    ballot       = 3'b000;
    res_ready    = 1'b1;
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0 || ballot_ready !== 1'b1) begin bad++; $display("FAIL t6_release got valid=%b ready=%b exp 0/1", res_valid, ballot_ready); end
  endtask

  initial begin
    rst_n        = 1'b0;
    ballot       = 3'b000;
    ballot_valid = 1'b0;
    res_ready    = 1'b0;
    test_reset();
    test_plurality();
    test_tie();
    test_bad_ballots();
    test_backpressure();
    test_mid_reset();
    test_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
